// File: rtl/pc_ir_unit.sv
// pc_ir_unit: upstream datapath stage of the multicycle processor.
// This block holds the program counter, the instruction register and the memory
// data register. It exposes the op/funct fields to the controller. It selects the
// next PC and the shared memory address, and counts IR loads.
module pc_ir_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pcen,
  input  logic             iord,
  input  logic             irwrite,
  input  logic [1:0]       pcsrc,
  input  logic [WIDTH-1:0] aluresult,
  input  logic [WIDTH-1:0] aluout,
  input  logic [WIDTH-1:0] readdata,
  output logic [WIDTH-1:0] adr,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] data,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic [31:0]      instcount
);

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,  // combinational ALU result (PC+4)
    PCSRC_ALUOUT = 2'b01,  // registered ALU result (branch target)
    PCSRC_JUMP   = 2'b10,  // pseudo-direct jump target
    PCSRC_HOLD   = 2'b11   // reserved encoding: keep the current PC
  } pcsrc_e;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [31:0]      instcount_q, instcount_d;
  logic [WIDTH-1:0] pcnext;
  logic [WIDTH-1:0] jump_target;

  // The jump target keeps the upper PC bits and replaces the rest with the word index from the IR.
  assign jump_target = {pc_q[WIDTH-1:28], instr_q[25:0], 2'b00};

  // Next-PC selection. An unknown or reserved select falls back to holding the PC.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    pcnext = pc_q;
    case (pcsrc_e'(pcsrc))
      PCSRC_ALU:    pcnext = aluresult;
      PCSRC_ALUOUT: pcnext = aluout;
      PCSRC_JUMP:   pcnext = jump_target;
      default:      pcnext = pc_q;
    endcase
  end

  // Shared memory address: the PC for fetches, aluout for data accesses.
  always_comb begin
    adr = pc_q;
    if (iord == 1'b1) adr = aluout;
  end

  // Next-state values for the architectural registers, driven only by controller strobes.
  always_comb begin
    pc_d        = pc_q;
    instr_d     = instr_q;
    instcount_d = instcount_q;
    data_d      = readdata;  // The MDR captures on every edge.
    if (pcen == 1'b1) pc_d = pcnext;
    if (irwrite == 1'b1) begin
      instr_d     = readdata;
      instcount_d = instcount_q + 32'd1;  // Wraps silently to zero.
    end
  end

  // State registers, cleared asynchronously and held while reset is high.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: these are plain registers, not a RAM array, so each one is reset explicitly.
    if (reset) begin
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      data_q      <= '0;
      instcount_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let the jump target use the pre-edge pc and instr.
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      data_q      <= data_d;
      instcount_q <= instcount_d;
    end
  end

  assign pc        = pc_q;
  assign instr     = instr_q;
  assign data      = data_q;
  assign instcount = instcount_q;
  assign op        = instr_q[31:26];
  assign funct     = instr_q[5:0];

endmodule

// File: tb/tb_pc_ir_unit.sv
// Testbench for pc_ir_unit.
// Directed scenarios and a randomized program are compared against a
// behavioural model of the PC, IR, MDR and fetch counter.
module tb_pc_ir_unit;

  localparam int          WIDTH    = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic             clk = 1'b0;
  logic             reset;
  logic             pcen, iord, irwrite;
  logic [1:0]       pcsrc;
  logic [WIDTH-1:0] aluresult, aluout, readdata;
  logic [WIDTH-1:0] adr, pc, instr, data;
  logic [5:0]       op, funct;
  logic [31:0]      instcount;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [31:0] m_pc, m_instr, m_data, m_count;

  pc_ir_unit #(.WIDTH(WIDTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .pcen(pcen), .iord(iord), .irwrite(irwrite),
    .pcsrc(pcsrc), .aluresult(aluresult), .aluout(aluout), .readdata(readdata),
    .adr(adr), .pc(pc), .instr(instr), .data(data), .op(op), .funct(funct),
    .instcount(instcount)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic pe, input logic io, input logic irw, input logic [1:0] src,
                       input logic [31:0] ares, input logic [31:0] aout, input logic [31:0] rd);
    pcen = pe; iord = io; irwrite = irw; pcsrc = src;
    aluresult = ares; aluout = aout; readdata = rd;
  endtask

  // Advance the model from the current inputs, then cross one rising edge and settle.
  task automatic tick();
    logic [31:0] nxt;
    case (pcsrc)
      2'd0:    nxt = aluresult;
      2'd1:    nxt = aluout;
      2'd2:    nxt = (m_pc & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 4);
      default: nxt = m_pc;
    endcase
    if (pcen) m_pc = nxt;
    if (irwrite) begin
      m_instr = readdata;
      m_count = m_count + 1;
    end
    m_data = readdata;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_instr = 0; m_data = 0; m_count = 0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h40, 0, 0);
    tick();
    total++;
    if (pc !== 32'h40) begin bad++; $display("FAIL reset_setup pc got=%h want=%h", pc, 32'h40); end
    #2 reset = 1'b1;
    model_reset();
    #1;
    total++;
    if (pc !== RESET_PC || instr !== 0 || instcount !== 0 || data !== 0) begin
      bad++; $display("FAIL reset_async pc=%h instr=%h cnt=%h data=%h want pc=%h rest 0",
                      pc, instr, instcount, data, RESET_PC);
    end
    drive(1'b1, 1'b0, 1'b1, 2'b00, 32'h80, 0, 32'hFFFF);
    @(posedge clk); #1;
    total++;
    if (pc !== RESET_PC || instr !== 0 || instcount !== 0) begin
      bad++; $display("FAIL reset_hold pc=%h instr=%h cnt=%h want pc=%h rest 0",
                      pc, instr, instcount, RESET_PC);
    end
    drive(1'b0, 1'b0, 1'b0, 2'b00, 0, 0, 0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    m_data = 0;
  endtask

  task automatic test_fetch();
    drive(1'b1, 1'b0, 1'b1, 2'b00, 32'h4, 0, 32'h2002_0005);
    total++;
    if (adr !== RESET_PC) begin bad++; $display("FAIL fetch_adr got=%h want=%h", adr, RESET_PC); end
    tick();
    total++;
    if (instr !== 32'h2002_0005 || op !== 6'h08 || funct !== 6'h05 || pc !== 32'h4 || instcount !== 1) begin
      bad++; $display("FAIL fetch instr=%h op=%h funct=%h pc=%h cnt=%0d want 20020005/08/05/4/1",
                      instr, op, funct, pc, instcount);
    end
  endtask

  task automatic test_jump();
    drive(1'b1, 1'b0, 1'b1, 2'b00, 32'h10, 0, 32'h0800_0011);
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'b10, 0, 0, 0);
    tick();
    total++;
    if (pc !== 32'h10) begin bad++; $display("FAIL jump_no_pcen pc got=%h want=%h", pc, 32'h10); end
    drive(1'b1, 1'b0, 1'b0, 2'b10, 0, 0, 0);
    tick();
    total++;
    if (pc !== 32'h44) begin bad++; $display("FAIL jump pc got=%h want=%h", pc, 32'h44); end
  endtask

  task automatic test_back_to_back();
    // Same-edge IR load and jump: the target comes from the old instr.
    drive(1'b1, 1'b0, 1'b1, 2'b10, 0, 0, 32'h0800_0020);
    tick();
    total++;
    if (pc !== 32'h44 || instr !== 32'h0800_0020) begin
      bad++; $display("FAIL b2b_same_edge pc=%h instr=%h want 44/08000020", pc, instr);
    end
    drive(1'b1, 1'b0, 1'b0, 2'b10, 0, 0, 0);
    tick();
    total++;
    if (pc !== 32'h80) begin bad++; $display("FAIL b2b_next_jump pc got=%h want=%h", pc, 32'h80); end
  endtask

  task automatic test_addr_mux();
    logic [31:0] old_instr;
    old_instr = instr;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 0, 32'h54, 32'hABCD);
    #1;
    total++;
    if (adr !== m_pc) begin bad++; $display("FAIL adr_pc got=%h want=%h", adr, m_pc); end
    iord = 1'b1;
    #1;
    total++;
    if (adr !== 32'h54) begin bad++; $display("FAIL adr_aluout got=%h want=%h", adr, 32'h54); end
    tick();
    total++;
    if (data !== 32'hABCD || instr !== m_instr) begin
      bad++; $display("FAIL mdr data=%h instr=%h want %h/%h (old %h)", data, instr, 32'hABCD, m_instr, old_instr);
    end
  endtask

  task automatic test_branch_hold();
    drive(1'b1, 1'b0, 1'b0, 2'b01, 32'h999, 32'h3C, 0);
    tick();
    total++;
    if (pc !== 32'h3C) begin bad++; $display("FAIL branch pc got=%h want=%h", pc, 32'h3C); end
    drive(1'b1, 1'b0, 1'b0, 2'b11, 32'h999, 32'h777, 0);
    tick();
    total++;
    if (pc !== 32'h3C) begin bad++; $display("FAIL hold pc got=%h want=%h", pc, 32'h3C); end
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b0, 1'b1, 2'b00, 0, 0, 32'h1234_5678);
    force dut.instcount_q = 32'hFFFF_FFFF;
    #1 release dut.instcount_q;
    m_count = 32'hFFFF_FFFF;
    #1;
    total++;
    if (instcount !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL wrap_preload got=%h want=%h", instcount, 32'hFFFF_FFFF);
    end
    tick();
    total++;
    if (instcount !== 0 || instr !== 32'h1234_5678) begin
      bad++; $display("FAIL wrap cnt=%h instr=%h want 0/12345678", instcount, instr);
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
            $urandom, $urandom, $urandom);
      #1;
      total++;
      if (adr !== (iord ? aluout : m_pc)) begin
        bad++; errs++; $display("FAIL rand_adr cycle=%0d got=%h want=%h", i, adr, iord ? aluout : m_pc);
      end
      tick();
      total++;
      if (pc !== m_pc || instr !== m_instr || data !== m_data || instcount !== m_count ||
          op !== m_instr[31:26] || funct !== m_instr[5:0]) begin
        bad++; errs++;
        $display("FAIL rand_state cycle=%0d pc=%h/%h instr=%h/%h data=%h/%h cnt=%0d/%0d",
                 i, pc, m_pc, instr, m_instr, data, m_data, instcount, m_count);
      end
      if (i == 200) begin
        // Mid-run reset restarts fetch at RESET_PC.
        #1 reset = 1'b1;
        model_reset();
        #1 reset = 1'b0;
        #1;
        total++;
        if (pc !== RESET_PC || instcount !== 0) begin
          bad++; errs++; $display("FAIL rand_reset pc=%h cnt=%0d want %h/0", pc, instcount, RESET_PC);
        end
      end
    end
    total++;
    if (errs !== 0) begin bad++; $display("FAIL rand_summary errors got=%0d want=0", errs); end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 0, 0, 0);
    model_reset();
    #12 reset = 1'b0;
    test_reset();
    test_fetch();
    test_jump();
    test_back_to_back();
    test_addr_mux();
    test_branch_hold();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bound the run so a stalled bench still terminates.
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
